// File: rtl/pwm_tick_driver_if.sv
// Duty-value handshake bundle between a host (master) and the PWM tick driver (slave).
interface pwm_tick_driver_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_tick_driver.sv
// PWM generator advanced by a prescaled tick; duty updates land only at period wrap.
// Optional breathe ramp enabled by defining PWM_BREATHE_EN.
module pwm_tick_driver #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned BREATHE_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               tick_i,
  pwm_tick_driver_if.slave   duty_if,
  output logic               pwm_out_o,
  output logic               period_done_o,
  output logic               running_o
);

  localparam int unsigned MAX_I = (32'd1 << WIDTH) - 32'd1;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  if ((BREATHE_STEP < 1) || (BREATHE_STEP > MAX_I)) begin : g_bad_step
    $error("BREATHE_STEP must lie in 1..2**WIDTH-1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;
  logic             run_q, run_d;
  logic             wrap_c;
  logic             accept_c;

`ifdef PWM_BREATHE_EN
  localparam logic [WIDTH:0] STEP = (WIDTH+1)'(BREATHE_STEP);
  logic             dir_q, dir_d;
  logic [WIDTH:0]   up_sum_c;
  assign up_sum_c = {1'b0, duty_act_q} + STEP;
`endif

  assign wrap_c             = (state_q == ST_RUN) && tick_i && (cnt_q == MAX);
  assign accept_c           = duty_if.duty_valid && !pend_full_q;
  assign duty_if.duty_ready = !pend_full_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // en is only honoured in IDLE or at wrap, so a started period always completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN:  if (wrap_c && !en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    duty_act_d  = duty_act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`ifdef PWM_BREATHE_EN
    dir_d       = dir_q;
`endif
    pwm_d  = (state_q == ST_RUN) && (cnt_q < duty_act_q);
    done_d = wrap_c;
    run_d  = (state_d == ST_RUN);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_full_q) begin
          duty_act_d  = pend_q;
          pend_full_d = 1'b0;
`ifdef PWM_BREATHE_EN
          dir_d       = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (tick_i) begin
          if (cnt_q == MAX) begin
            cnt_d = '0;
            if (pend_full_q) begin
              duty_act_d  = pend_q;
              pend_full_d = 1'b0;
`ifdef PWM_BREATHE_EN
              dir_d       = 1'b0;
            end else if (!dir_q) begin
              if (up_sum_c >= {1'b0, MAX}) begin
                duty_act_d = MAX;
                dir_d      = 1'b1;
              end else begin
                duty_act_d = up_sum_c[WIDTH-1:0];
              end
            end else begin
              if ({1'b0, duty_act_q} <= STEP) begin
                duty_act_d = '0;
                dir_d      = 1'b0;
              end else begin
                duty_act_d = duty_act_q - STEP[WIDTH-1:0];
              end
`endif
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      default: ;
    endcase

    // accept only into an empty shadow, so this never collides with the transfer above
    if (accept_c) begin
      pend_d      = duty_if.duty_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      duty_act_q  <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
`ifdef PWM_BREATHE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      duty_act_q  <= duty_act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pwm_q       <= pwm_d;
      done_q      <= done_d;
      run_q       <= run_d;
`ifdef PWM_BREATHE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign pwm_out_o     = pwm_q;
  assign period_done_o = done_q;
  assign running_o     = run_q;

endmodule

// File: tb/tb_pwm_tick_driver.sv
// Self-checking bench for pwm_tick_driver: vector table, directed corner sequences, random vs model.
module tb_pwm_tick_driver;

  localparam int W     = 4;
  localparam int MAXV  = 15;
  localparam int STEPV = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_i, tick_i;
  logic pwm_out_o, period_done_o, running_o;

  pwm_tick_driver_if #(.WIDTH(W)) duty_if ();

  pwm_tick_driver #(.WIDTH(W), .BREATHE_STEP(STEPV)) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .tick_i        (tick_i),
    .duty_if       (duty_if),
    .pwm_out_o     (pwm_out_o),
    .period_done_o (period_done_o),
    .running_o     (running_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tick_per = 1;
  int tp_cnt   = 0;

  // reference model: run flag, tick index into the period, active duty, shadow queue
  bit m_run, m_pwm, m_done, m_dir;
  int m_idx, m_duty;
  int m_pend[$];

  typedef struct {
    int duty;
    int tp;
    int exp_hi;
    int exp_len;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit s_rst, input bit s_en, input bit s_tick,
                            input bit s_valid, input int s_din);
    bit acc;
    if (s_rst) begin
      m_run = 0; m_idx = 0; m_duty = 0; m_pwm = 0; m_done = 0; m_dir = 0;
      m_pend.delete();
    end else begin
      m_pwm  = m_run && (m_idx < m_duty);
      m_done = 0;
      acc    = s_valid && (m_pend.size() == 0);
      if (!m_run) begin
        m_idx = 0;
        if (m_pend.size() > 0) begin m_duty = m_pend.pop_front(); m_dir = 0; end
        m_run = s_en;
      end else if (s_tick) begin
        if (m_idx == MAXV) begin
          m_idx  = 0;
          m_done = 1;
          if (m_pend.size() > 0) begin
            m_duty = m_pend.pop_front();
            m_dir  = 0;
          end
`ifdef PWM_BREATHE_EN
          else if (!m_dir) begin
            if (m_duty + STEPV >= MAXV) begin m_duty = MAXV; m_dir = 1; end
            else m_duty = m_duty + STEPV;
          end else begin
            if (m_duty <= STEPV) begin m_duty = 0; m_dir = 0; end
            else m_duty = m_duty - STEPV;
          end
`endif
          if (!s_en) m_run = 0;
        end else begin
          m_idx++;
        end
      end
      if (acc) m_pend.push_back(s_din);
    end
  endtask

  task automatic step();
    bit s_rst, s_en, s_tick, s_valid;
    int s_din;
    if (tick_per == 0) tick_i = 1'($urandom_range(0, 1));
    else begin
      tick_i = (tp_cnt == tick_per - 1);
      tp_cnt = (tp_cnt + 1) % tick_per;
    end
    s_rst = rst; s_en = en_i; s_tick = tick_i;
    s_valid = duty_if.duty_valid; s_din = int'(duty_if.duty_in);
    @(posedge clk);
    model_edge(s_rst, s_en, s_tick, s_valid, s_din);
    #1;
  endtask

  task automatic set_tick(input int tp);
    tick_per = tp;
    tp_cnt   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_i = 1'b0; duty_if.duty_valid = 1'b0; duty_if.duty_in = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic load(input int d);
    duty_if.duty_in    = W'(d);
    duty_if.duty_valid = 1'b1;
    step();
    duty_if.duty_valid = 1'b0;
  endtask

  // second load lands in the shadow during period 1, so period 2 runs at d in either build
  task automatic start_run(input int d);
    load(d);
    en_i = 1'b1;
    step();
    load(d);
  endtask

  task automatic count_to_done(output int hi, output int len);
    bit seen;
    hi = 0; len = 0; seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      len++;
      if (pwm_out_o) hi++;
      if (period_done_o) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL period_timeout: got no period_done in %0d cycles, expected one", len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, len, h2, l2, run_cnt, dn_cnt;
    vecs[0] = '{4, 1, 4, 16};
    vecs[1] = '{15, 4, 60, 64};
    vecs[2] = '{0, 1, 0, 16};
    vecs[3] = '{15, 1, 15, 16};
    vecs[4] = '{1, 2, 2, 32};
    vecs[5] = '{8, 3, 24, 48};

    rst = 1'b1; en_i = 1'b0; tick_i = 1'b0;
    duty_if.duty_valid = 1'b0; duty_if.duty_in = '0;
    m_run = 0; m_pwm = 0; m_done = 0; m_dir = 0; m_idx = 0; m_duty = 0;

    set_tick(1);
    do_reset();
    check("rst_pwm", int'(pwm_out_o), 0);
    check("rst_done", int'(period_done_o), 0);
    check("rst_running", int'(running_o), 0);
    check("rst_ready", int'(duty_if.duty_ready), 1);

    foreach (vecs[i]) begin
      set_tick(vecs[i].tp);
      do_reset();
      start_run(vecs[i].duty);
      count_to_done(hi, len);
      count_to_done(hi, len);
      check($sformatf("vec%0d_high", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d_running", i), int'(running_o), 1);
    end

    // mid-period load waits for the wrap
    set_tick(1);
    do_reset();
    start_run(4);
    count_to_done(hi, len);
    hi = 0;
    for (int i = 0; i < 3; i++) begin step(); if (pwm_out_o) hi++; end
    load(10);
    if (pwm_out_o) hi++;
    check("mid_ready_low", int'(duty_if.duty_ready), 0);
    count_to_done(h2, l2);
    check("mid_old_high", hi + h2, 4);
    check("mid_ready_after_wrap", int'(duty_if.duty_ready), 1);
    count_to_done(hi, len);
    check("mid_new_high", hi, 10);
    check("mid_new_len", len, 16);

    // en dropped at cnt=5 finishes the period then idles
    do_reset();
    start_run(4);
    count_to_done(hi, len);
    for (int i = 0; i < 5; i++) step();
    en_i = 1'b0;
    count_to_done(hi, len);
    check("endrop_period_len", 5 + len, 16);
    check("endrop_running_at_wrap", int'(running_o), 0);
    hi = 0; run_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pwm_out_o) hi++;
      if (running_o) run_cnt++;
      if (period_done_o) dn_cnt++;
    end
    check("endrop_idle_high", hi, 0);
    check("endrop_idle_running", run_cnt, 0);
    check("endrop_idle_done", dn_cnt, 0);

    // reset at cnt=7 with a full shadow discards the pending duty
    do_reset();
    start_run(4);
    count_to_done(hi, len);
    for (int i = 0; i < 3; i++) step();
    load(10);
    check("rstmid_pend_full", int'(duty_if.duty_ready), 0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_pwm", int'(pwm_out_o), 0);
    check("rstmid_ready", int'(duty_if.duty_ready), 1);
    check("rstmid_running", int'(running_o), 0);
    check("rstmid_done", int'(period_done_o), 0);
    count_to_done(hi, len);
    check("rstmid_first_high", hi, 0);
    count_to_done(hi, len);
`ifdef PWM_BREATHE_EN
    check("rstmid_second_high", hi, 5);
`else
    check("rstmid_second_high", hi, 0);
`endif

`ifdef PWM_BREATHE_EN
    begin
      int ramp[8];
      ramp = '{0, 5, 10, 15, 10, 5, 0, 5};
      do_reset();
      en_i = 1'b1;
      for (int p = 0; p < 8; p++) begin
        count_to_done(hi, len);
        check($sformatf("breathe_p%0d_high", p), hi, ramp[p]);
      end
      hi = 0;
      for (int i = 0; i < 3; i++) begin step(); if (pwm_out_o) hi++; end
      load(3);
      if (pwm_out_o) hi++;
      count_to_done(h2, l2);
      check("breathe_load_cur_high", hi + h2, 10);
      count_to_done(hi, len);
      check("breathe_load_next_high", hi, 3);
      count_to_done(hi, len);
      check("breathe_load_after_high", hi, 8);
    end
`endif

    // randomized traffic against the model
    do_reset();
    set_tick(0);
    for (int i = 0; i < 3000; i++) begin
      rst                = ($urandom_range(0, 199) == 0);
      en_i               = ($urandom_range(0, 9) != 0);
      duty_if.duty_valid = ($urandom_range(0, 3) == 0);
      duty_if.duty_in    = W'($urandom_range(0, MAXV));
      step();
      check("rand_pwm", int'(pwm_out_o), int'(m_pwm));
      check("rand_done", int'(period_done_o), int'(m_done));
      check("rand_running", int'(running_o), int'(m_run));
      check("rand_ready", int'(duty_if.duty_ready), int'(m_pend.size() == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
